// File: rtl/uart_cmd_parser_if.sv
// Command handshake bundle between uart_cmd_parser (master) and its consumer (slave).
// MAX_LEN must match the parser's MAX_LEN so the payload widths agree.
interface uart_cmd_parser_if #(
  parameter int MAX_LEN = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_code;
  logic [5:0]           cmd_len;
  logic [MAX_LEN*8-1:0] cmd_payload;

  modport master (
    output cmd_valid,
    output cmd_code,
    output cmd_len,
    output cmd_payload,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    input  cmd_len,
    input  cmd_payload,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles host frames (SOF 0xA5, CMD, LEN, payload, CHK) from
// UART receiver bytes and presents checked commands on a valid/ready port.
// Error codes: 1=checksum 2=length 3=line 4=timeout 5=overrun, one-cycle pulse.
// Optional feature: define UART_CMD_TIMEOUT_EN to enable the inter-byte timeout
// (adds the TIMEOUT_CYCLES parameter); without it partial frames wait forever.
module uart_cmd_parser #(
  parameter int MAX_LEN = 8
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 84_000
`endif
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  input  logic                byte_err,
  uart_cmd_parser_if.master   cmd,
  output logic                err_valid,
  output logic [2:0]          err_code
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  localparam logic [2:0] E_CHECKSUM = 3'd1;
  localparam logic [2:0] E_LENGTH   = 3'd2;
  localparam logic [2:0] E_LINE     = 3'd3;
`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [2:0] E_TIMEOUT  = 3'd4;
`endif
  localparam logic [2:0] E_OVERRUN  = 3'd5;

  logic [2:0]           state;
  logic [7:0]           code_q;
  logic [5:0]           len_q;
  logic [MAX_LEN*8-1:0] payload_q;
  logic [5:0]           cnt;
  logic [7:0]           sum;
  logic                 valid_q;
  logic                 sof;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic          timeout_hit;
  assign timeout_hit = (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  assign sof = byte_valid && !byte_err && (byte_data == 8'hA5);

  assign cmd.cmd_valid   = valid_q;
  assign cmd.cmd_code    = code_q;
  assign cmd.cmd_len     = len_q;
  assign cmd.cmd_payload = payload_q;

  // Frame FSM: byte assembly, running checksum, command hold and error pulses.
  // An accepted command frees HOLD in the same cycle, so a simultaneous 0xA5
  // is treated exactly as it would be in IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      code_q    <= '0;
      len_q     <= '0;
      payload_q <= '0;
      cnt       <= '0;
      sum       <= '0;
      valid_q   <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      err_valid <= 1'b0;
      err_code  <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      if (state == S_IDLE || state == S_HOLD || byte_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
`endif
      case (state)
        S_IDLE: begin
          if (sof) begin
            state     <= S_CMD;
            payload_q <= '0;
            sum       <= '0;
            cnt       <= '0;
          end
        end

        S_CMD, S_LEN, S_PAYLOAD, S_CHK: begin
          if (byte_valid && byte_err) begin
            err_valid <= 1'b1;
            err_code  <= E_LINE;
            state     <= S_IDLE;
          end else if (byte_valid) begin
            case (state)
              S_CMD: begin
                code_q <= byte_data;
                sum    <= byte_data;
                state  <= S_LEN;
              end
              S_LEN: begin
                if (byte_data > 8'(MAX_LEN)) begin
                  err_valid <= 1'b1;
                  err_code  <= E_LENGTH;
                  state     <= S_IDLE;
                end else begin
                  len_q <= byte_data[5:0];
                  sum   <= sum + byte_data;
                  cnt   <= '0;
                  state <= (byte_data == 8'd0) ? S_CHK : S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                  if (cnt == 6'(i)) payload_q[8*i +: 8] <= byte_data;
                end
                sum <= sum + byte_data;
                cnt <= cnt + 6'd1;
                if (cnt + 6'd1 == len_q) state <= S_CHK;
              end
              default: begin
                if (byte_data == sum) begin
                  valid_q <= 1'b1;
                  state   <= S_HOLD;
                end else begin
                  err_valid <= 1'b1;
                  err_code  <= E_CHECKSUM;
                  state     <= S_IDLE;
                end
              end
            endcase
`ifdef UART_CMD_TIMEOUT_EN
          end else if (timeout_hit) begin
            err_valid <= 1'b1;
            err_code  <= E_TIMEOUT;
            state     <= S_IDLE;
`endif
          end
        end

        S_HOLD: begin
          if (cmd.cmd_ready) begin
            valid_q <= 1'b0;
            if (sof) begin
              state     <= S_CMD;
              payload_q <= '0;
              sum       <= '0;
              cnt       <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else if (byte_valid && !byte_err) begin
            err_valid <= 1'b1;
            err_code  <= E_OVERRUN;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
